powlib_edge: RTL and testbench
==============================

POWLIB_EDGE -- requirements
Module: powlib_edge

Interface
REQ-001 Parameter W, default 1: data width in bits, legal range 1 to 64.
REQ-002 Parameter INIT, default 0: W-bit value loaded into the previous-sample register on reset.
REQ-003 Parameter EAR, default 0: selects the output stage; 0 = combinational, 1 = registered (adds one cycle of latency).
REQ-004 Parameter EHN, default 1: 1 enables falling-edge (1->0) detection.
REQ-005 Parameter EHP, default 1: 1 enables rising-edge (0->1) detection.
REQ-006 Parameter EVLD, default 0: 1 qualifies sampling and outputs with vld; 0 ignores vld.
REQ-007 clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-008 rst, input, 1 bit: asynchronous, active-high reset.
REQ-009 vld, input, 1 bit: input-valid qualifier; used only when EVLD=1.
REQ-010 din, input, W bits: monitored vector.
REQ-011 pos, output, W bits: per-bit rising-edge flags; tied to 0 when EHP=0.
REQ-012 neg, output, W bits: per-bit falling-edge flags; tied to 0 when EHN=0.
REQ-013 dout, output, W bits: equals pos OR neg.
REQ-014 ovld, output, 1 bit: asserted when the current flags are valid.

Function
REQ-015 The module SHALL hold a W-bit register prev.
- EVLD=0: prev loads din on every clock.
- EVLD=1: prev loads din only on clocks where vld=1.
REQ-016 The raw flags SHALL be computed per bit:
- rise = din AND NOT prev
- fall = NOT din AND prev
REQ-017 When EVLD=1, raw rise and raw fall SHALL be ANDed with vld; when vld=0, prev holds its value and the flags are 0.
REQ-018 The raw ovld SHALL equal vld when EVLD=1, and constant 1 when EVLD=0.
REQ-019 EAR=0: pos, neg, dout and ovld SHALL be combinational from din, vld and prev (zero latency).
REQ-020 EAR=1: pos, neg, dout and ovld SHALL be registered copies of the raw values, appearing one clock after the input.
REQ-021 Each bit SHALL be independent; simultaneous rising and falling edges on different bits SHALL both be reported in the same cycle.
REQ-022 A stable din SHALL produce no flags, and each edge SHALL produce exactly one flag cycle.

Reset
REQ-023 rst=1 SHALL immediately set prev to INIT, independent of clk.
REQ-024 When EAR=1, rst=1 SHALL immediately clear the registered pos, neg, dout and ovld to 0.
REQ-025 On the first clock after rst is released, din SHALL be compared against INIT, so a difference from INIT reports an edge.
REQ-026 Reset asserted mid-pulse SHALL abort the pulse; the registered outputs show 0 at once, and combinational outputs reflect the new prev=INIT.

Configuration
REQ-027 Macro POWLIB_EDGE_PARAMCHK_EN, when defined, SHALL add elaboration-time checks that stop with an error on any of:
- EHN=0 and EHP=0
- W outside 1 to 64
- INIT wider than W
REQ-028 Without POWLIB_EDGE_PARAMCHK_EN, no checks are compiled, and an EHN=EHP=0 build SHALL drive pos, neg and dout to 0.

Verification
REQ-029 W=13, EHP=1, EHN=0, EVLD=0, EAR=0, INIT=0:
- din steps 0 -> 0x1005 -> 0x1005 -> pos=0x1005 for exactly one cycle, then 0.
- din 0x1005 -> 0 -> neg stays 0.
REQ-030 W=7, EHN=1, EHP=0, din 0x7F -> 0x10 -> neg=0x6F for one cycle; pos stays 0.
REQ-031 W=32, EHN=1, EHP=1, din 0xFFFF0000 -> 0x0000FFFF:
- pos=0x0000FFFF, neg=0xFFFF0000, dout=0xFFFFFFFF for one cycle.
REQ-032 W=3, EVLD=1, EHN=1, EHP=1, din 0 -> 5 with vld=0 for 3 cycles, then vld=1:
- dout=0 and ovld=0 while vld=0.
- dout=5 and ovld=1 on the first vld=1 cycle.
- dout=0 on the next vld=1 cycle with din unchanged.
REQ-033 W=20, EHP=1, EVLD=1, EAR=1:
- din 0 -> 0xABCDE with vld=1 -> pos=0xABCDE one clock later.
- Assert rst asynchronously between clock edges -> pos, dout and ovld clear to 0 before the next clock edge.
REQ-034 W=1, EHN=1, EVLD=1, INIT=1, din held 0 during reset:
- After rst release, first vld=1 cycle -> neg=1 (edge against INIT).

Source files
------------

// File: rtl/powlib_edge.sv
// powlib_edge -- per-bit rising/falling edge detector.
//
// Each bit of din is compared against a previous-sample register (prev).
// A 0->1 step raises the matching pos bit, a 1->0 step raises the matching
// neg bit, and dout is their OR. With EVLD=1 the vld input gates both the
// sampling of prev and the flags; otherwise every clock samples. EAR selects
// a combinational (0) or one-cycle registered (1) output stage.
//
// Parameters:
//   W     data width, 1..64
//   INIT  value loaded into prev on reset (low W bits used)
//   EAR   0 = combinational outputs, 1 = registered outputs
//   EHN   1 = report falling edges on neg
//   EHP   1 = report rising edges on pos
//   EVLD  1 = qualify sampling and outputs with vld
//
// Ports:
//   clk   clock, rising edge
//   rst   asynchronous active-high reset
//   vld   input qualifier (ignored unless EVLD=1)
//   din   monitored vector, W bits
//   pos   per-bit rising-edge flags
//   neg   per-bit falling-edge flags
//   dout  pos | neg
//   ovld  flags valid
//
// Build option: define POWLIB_EDGE_PARAMCHK_EN to add elaboration-time
// parameter legality checks.

// Per-bit slice: owns one prev bit and produces that bit's raw flags.
module powlib_edge_bit #(
  parameter bit INIT_B = 1'b0,
  parameter bit EHN    = 1'b1,
  parameter bit EHP    = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic smp,
  input  logic din,
  output logic rise,
  output logic fall
);
  logic prev_q, prev_d;

  // prev only advances on sampled cycles, so an unsampled input is
  // compared later against the last accepted value.
  always_comb begin
    prev_d = prev_q;
    if (smp) prev_d = din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev_q <= INIT_B;
    else     prev_q <= prev_d;
  end

  always_comb begin
    rise = 1'b0;
    fall = 1'b0;
    if (smp) begin
      rise = EHP & din & ~prev_q;
      fall = EHN & ~din & prev_q;
    end
  end
endmodule

module powlib_edge #(
  parameter int          W    = 1,
  parameter logic [63:0] INIT = 64'd0,
  parameter int          EAR  = 0,
  parameter int          EHN  = 1,
  parameter int          EHP  = 1,
  parameter int          EVLD = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         vld,
  input  logic [W-1:0] din,
  output logic [W-1:0] pos,
  output logic [W-1:0] neg,
  output logic [W-1:0] dout,
  output logic         ovld
);

`ifdef POWLIB_EDGE_PARAMCHK_EN
  if (EHN == 0 && EHP == 0) begin : g_chk_dir
    $error("powlib_edge: EHN and EHP both 0, no edge can be reported");
  end
  if (W < 1 || W > 64) begin : g_chk_w
    $error("powlib_edge: W=%0d outside 1..64", W);
  end
  if ((INIT >> W) != 64'd0) begin : g_chk_init
    $error("powlib_edge: INIT does not fit in W=%0d bits", W);
  end
`endif

  // Sample enable: forced high when vld qualification is off. Written as an
  // OR so vld is always read, keeping the port live in every configuration.
  logic smp;
  assign smp = vld | (EVLD == 0);

  logic [W-1:0] rise_raw, fall_raw;

  for (genvar i = 0; i < W; i++) begin : g_bit
    powlib_edge_bit #(
      .INIT_B (INIT[i]),
      .EHN    (EHN != 0),
      .EHP    (EHP != 0)
    ) u_bit (
      .clk  (clk),
      .rst  (rst),
      .smp  (smp),
      .din  (din[i]),
      .rise (rise_raw[i]),
      .fall (fall_raw[i])
    );
  end

  if (EAR != 0) begin : g_reg
    logic [W-1:0] pos_q, pos_d, neg_q, neg_d;
    logic         ovld_q, ovld_d;

    always_comb begin
      pos_d  = rise_raw;
      neg_d  = fall_raw;
      ovld_d = smp;
    end

    // Reset clears the output stage immediately, aborting any pulse.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        pos_q  <= '0;
        neg_q  <= '0;
        ovld_q <= 1'b0;
      end else begin
        pos_q  <= pos_d;
        neg_q  <= neg_d;
        ovld_q <= ovld_d;
      end
    end

    assign pos  = pos_q;
    assign neg  = neg_q;
    assign ovld = ovld_q;
  end else begin : g_comb
    assign pos  = rise_raw;
    assign neg  = fall_raw;
    assign ovld = smp;
  end

  assign dout = pos | neg;
endmodule

// File: tb/tb_powlib_edge.sv
module tb_powlib_edge;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // ---- DUT instances, one per scenario ----
  logic [12:0] din29 = '0, pos29, neg29, dout29; logic ovld29;
  logic [6:0]  din30 = '0, pos30, neg30, dout30; logic ovld30;
  logic [31:0] din31 = '0, pos31, neg31, dout31; logic ovld31;
  logic [2:0]  din32 = '0, pos32, neg32, dout32; logic ovld32; logic vld32 = 1'b0;
  logic [19:0] din33 = '0, pos33, neg33, dout33; logic ovld33; logic vld33 = 1'b0;
  logic [0:0]  din34 = '0, pos34, neg34, dout34; logic ovld34; logic vld34 = 1'b1;
  logic        vld_x = 1'b0;

  powlib_edge #(.W(13), .EHP(1), .EHN(0), .EVLD(0), .EAR(0), .INIT(64'd0)) u29 (
    .clk(clk), .rst(rst), .vld(vld_x), .din(din29),
    .pos(pos29), .neg(neg29), .dout(dout29), .ovld(ovld29));
  powlib_edge #(.W(7), .EHN(1), .EHP(0)) u30 (
    .clk(clk), .rst(rst), .vld(vld_x), .din(din30),
    .pos(pos30), .neg(neg30), .dout(dout30), .ovld(ovld30));
  powlib_edge #(.W(32), .EHN(1), .EHP(1)) u31 (
    .clk(clk), .rst(rst), .vld(vld_x), .din(din31),
    .pos(pos31), .neg(neg31), .dout(dout31), .ovld(ovld31));
  powlib_edge #(.W(3), .EVLD(1), .EHN(1), .EHP(1)) u32 (
    .clk(clk), .rst(rst), .vld(vld32), .din(din32),
    .pos(pos32), .neg(neg32), .dout(dout32), .ovld(ovld32));
  powlib_edge #(.W(20), .EHP(1), .EVLD(1), .EAR(1)) u33 (
    .clk(clk), .rst(rst), .vld(vld33), .din(din33),
    .pos(pos33), .neg(neg33), .dout(dout33), .ovld(ovld33));
  powlib_edge #(.W(1), .EHN(1), .EVLD(1), .INIT(64'd1)) u34 (
    .clk(clk), .rst(rst), .vld(vld34), .din(din34),
    .pos(pos34), .neg(neg34), .dout(dout34), .ovld(ovld34));

  // ---- observation selectors ----
  localparam int P29 = 0,  N29 = 1,  D29 = 2,  V29 = 3;
  localparam int P30 = 4,  N30 = 5,  D30 = 6;
  localparam int P31 = 7,  N31 = 8,  D31 = 9;
  localparam int P32 = 10, N32 = 11, D32 = 12, V32 = 13;
  localparam int P33 = 14, N33 = 15, D33 = 16, V33 = 17;
  localparam int N34 = 18;

  function automatic logic [63:0] obs(int sel);
    case (sel)
      P29: return 64'(pos29);  N29: return 64'(neg29);
      D29: return 64'(dout29); V29: return 64'(ovld29);
      P30: return 64'(pos30);  N30: return 64'(neg30);  D30: return 64'(dout30);
      P31: return 64'(pos31);  N31: return 64'(neg31);  D31: return 64'(dout31);
      P32: return 64'(pos32);  N32: return 64'(neg32);
      D32: return 64'(dout32); V32: return 64'(ovld32);
      P33: return 64'(pos33);  N33: return 64'(neg33);
      D33: return 64'(dout33); V33: return 64'(ovld33);
      N34: return 64'(neg34);
      default: return 64'hDEAD;
    endcase
  endfunction

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---- scoreboard ----
  typedef struct {
    int          due;
    int          sel;
    logic [63:0] exp;
    string       tag;
  } sb_t;
  sb_t sbq[$];

  task automatic exp_push(int sel, int lat, logic [63:0] v, string tag);
    sb_t e;
    e.due = cyc + lat;
    e.sel = sel;
    e.exp = v;
    e.tag = tag;
    sbq.push_back(e);
  endtask

  task automatic sb_drain(int c);
    sb_t keep[$];
    for (int i = 0; i < sbq.size(); i++) begin
      if (sbq[i].due == c) chk(sbq[i].tag, obs(sbq[i].sel), sbq[i].exp);
      else                 keep.push_back(sbq[i]);
    end
    sbq = keep;
  endtask

  always @(negedge clk) sb_drain(cyc);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state: registered outputs cleared, comb outputs from prev=INIT.
    step(); step();
    exp_push(P33, 0, 0, "rst_pos33");
    exp_push(D33, 0, 0, "rst_dout33");
    exp_push(V33, 0, 0, "rst_ovld33");
    exp_push(P29, 0, 0, "rst_pos29");
    exp_push(V29, 0, 1, "rst_ovld29");
    exp_push(N34, 0, 1, "rst_neg34_init");

    // First cycle after release: din34=0 compared against INIT=1.
    step(); rst = 1'b0;
    exp_push(N34, 0, 1, "rel_neg34");
    step();
    exp_push(N34, 0, 0, "rel_neg34_once");

    // W=13 rising-only.
    din29 = 13'h1005;
    exp_push(P29, 0, 64'h1005, "r29_pos");
    exp_push(N29, 0, 0,        "r29_neg");
    exp_push(D29, 0, 64'h1005, "r29_dout");
    exp_push(V29, 0, 1,        "r29_ovld");
    step();
    exp_push(P29, 0, 0, "r29_pos_once");
    step(); din29 = '0;
    exp_push(N29, 0, 0, "r29_fall_neg");
    exp_push(P29, 0, 0, "r29_fall_pos");
    exp_push(D29, 0, 0, "r29_fall_dout");

    // W=7 falling-only.
    step(); din30 = 7'h7F;
    exp_push(P30, 0, 0, "r30_rise_pos");
    exp_push(D30, 0, 0, "r30_rise_dout");
    step(); din30 = 7'h10;
    exp_push(N30, 0, 64'h6F, "r30_neg");
    exp_push(P30, 0, 0,      "r30_pos");
    exp_push(D30, 0, 64'h6F, "r30_dout");
    step();
    exp_push(N30, 0, 0, "r30_neg_once");

    // W=32 both directions in one cycle.
    step(); din31 = 32'hFFFF_0000;
    exp_push(P31, 0, 64'hFFFF_0000, "r31_pre_pos");
    exp_push(N31, 0, 0,             "r31_pre_neg");
    step(); din31 = 32'h0000_FFFF;
    exp_push(P31, 0, 64'h0000_FFFF, "r31_pos");
    exp_push(N31, 0, 64'hFFFF_0000, "r31_neg");
    exp_push(D31, 0, 64'hFFFF_FFFF, "r31_dout");
    step();
    exp_push(D31, 0, 0, "r31_dout_once");

    // W=3 vld-qualified: edge held off until vld rises.
    for (int k = 0; k < 3; k++) begin
      step(); din32 = 3'd5; vld32 = 1'b0;
      exp_push(D32, 0, 0, "r32_novld_dout");
      exp_push(V32, 0, 0, "r32_novld_ovld");
    end
    step(); vld32 = 1'b1;
    exp_push(D32, 0, 5, "r32_dout");
    exp_push(P32, 0, 5, "r32_pos");
    exp_push(N32, 0, 0, "r32_neg");
    exp_push(V32, 0, 1, "r32_ovld");
    step();
    exp_push(D32, 0, 0, "r32_dout_once");
    exp_push(V32, 0, 1, "r32_ovld_hold");

    // W=20 registered output, then async reset mid-pulse.
    step(); vld33 = 1'b1; din33 = '0;
    exp_push(P33, 1, 0, "r33_idle_pos");
    exp_push(V33, 1, 1, "r33_idle_ovld");
    step(); din33 = 20'hABCDE;
    exp_push(P33, 1, 64'hABCDE, "r33_pos");
    exp_push(D33, 1, 64'hABCDE, "r33_dout");
    exp_push(N33, 1, 0,         "r33_neg");
    exp_push(V33, 1, 1,         "r33_ovld");
    step();
    #5 rst = 1'b1;
    #1;
    exp_push(P33, 0, 0, "ar33_pos");
    exp_push(D33, 0, 0, "ar33_dout");
    exp_push(V33, 0, 0, "ar33_ovld");
    exp_push(N34, 0, 1, "ar34_neg_init");
    sb_drain(cyc);
    step(); rst = 1'b0;
    // prev33 back at INIT=0 so held din reports again after release.
    exp_push(P33, 1, 64'hABCDE, "rel33_pos");
    exp_push(V33, 1, 1,         "rel33_ovld");
    step(); step(); step();

    chk("sb_leftover", 64'(sbq.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
